// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// pipeline_hazard_ctrl: stall/flush control for a 5-stage RISC-V pipeline.
// Optional macro HAZARD_PERF_EN adds performance counters. Rev 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             ex_MemRead,
   input  logic [4:0]       ex_rd,
   input  logic             ex_redirect,
   input  logic             m_MemRead,
   input  logic             m_MemWrite,
   input  logic             dmem_ack,
   output logic             dmem_req,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_stall,
   output logic             id_ex_flush,
   output logic             ex_m_stall,
   output logic             m_wb_flush,
   output logic             mem_err,
   output logic [CNT_W-1:0] loaduse_cnt,
   output logic [CNT_W-1:0] memstall_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [15:0] C_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [15:0] tmo_q, tmo_d;
   logic        err_q, err_d;

   logic w_mem_access;
   logic w_busy;
   logic w_redir;
   logic w_hazard;
   logic w_lu;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         tmo_q   <= 16'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

   assign w_mem_access = m_MemRead || m_MemWrite;

   // Ack is tested before the timeout so a late ack still completes cleanly.
   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (w_mem_access) state_d = S_REQ;
         end
         S_REQ: begin
            if (dmem_ack) begin
               state_d = S_DONE;
               tmo_d   = 16'd0;
            end else if (tmo_q == C_TMO_LAST) begin
               state_d = S_DONE;
               tmo_d   = 16'd0;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are gated by rst_n so everything reads 0 while reset is held.
   assign w_busy   = rst_n && (((state_q == S_IDLE) && w_mem_access) || (state_q == S_REQ));
   assign w_redir  = rst_n && !w_busy && ex_redirect;
   assign w_hazard = ex_MemRead && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
   assign w_lu     = rst_n && !w_busy && !ex_redirect && w_hazard;

   assign dmem_req    = (state_q == S_REQ);
   assign pc_stall    = w_busy || w_lu;
   assign if_id_stall = w_busy || w_lu;
   assign id_ex_stall = w_busy;
   assign ex_m_stall  = w_busy;
   assign m_wb_flush  = w_busy;
   assign if_id_flush = w_redir;
   assign id_ex_flush = w_redir || w_lu;
   assign mem_err     = err_q;

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] lu_cnt_q;
   logic [CNT_W-1:0] ms_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lu_cnt_q <= '0;
         ms_cnt_q <= '0;
      end else begin
         if (w_lu && !(&lu_cnt_q))   lu_cnt_q <= lu_cnt_q + CNT_W'(1);
         if (w_busy && !(&ms_cnt_q)) ms_cnt_q <= ms_cnt_q + CNT_W'(1);
      end
   end

   assign loaduse_cnt  = lu_cnt_q;
   assign memstall_cnt = ms_cnt_q;
`else
   assign loaduse_cnt  = '0;
   assign memstall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// tb_pipeline_hazard_ctrl: directed bench with a cycle model of the controller.
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

   localparam int TMO   = 4;
   localparam int CW    = 8;
   localparam int SAT   = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [4:0]    id_rs1 = 5'd0, id_rs2 = 5'd0, ex_rd = 5'd0;
   logic          ex_MemRead = 1'b0, ex_redirect = 1'b0;
   logic          m_MemRead = 1'b0, m_MemWrite = 1'b0, dmem_ack = 1'b0;
   logic          dmem_req, pc_stall, if_id_stall, if_id_flush, id_ex_stall;
   logic          id_ex_flush, ex_m_stall, m_wb_flush, mem_err;
   logic [CW-1:0] loaduse_cnt, memstall_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .ex_MemRead(ex_MemRead), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
      .m_MemRead(m_MemRead), .m_MemWrite(m_MemWrite), .dmem_ack(dmem_ack),
      .dmem_req(dmem_req), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
      .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
      .ex_m_stall(ex_m_stall), .m_wb_flush(m_wb_flush), .mem_err(mem_err),
      .loaduse_cnt(loaduse_cnt), .memstall_cnt(memstall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: an access is "waiting" for some number of request cycles, or is
   // in its single release cycle; x0 and priorities come straight from the rules.
   bit mdl_req;
   int mdl_waited;
   bit mdl_release;
   bit mdl_err;
   int mdl_lu;
   int mdl_ms;

   function automatic bit f_busy();
      return rst_n && (mdl_req || (!mdl_release && (m_MemRead || m_MemWrite)));
   endfunction
   function automatic bit f_redir();
      return rst_n && !f_busy() && ex_redirect;
   endfunction
   function automatic bit f_lu();
      bit hit;
      hit = ex_MemRead && (ex_rd != 0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
      return rst_n && !f_busy() && !ex_redirect && hit;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdl_req = 0; mdl_waited = 0; mdl_release = 0; mdl_err = 0;
         mdl_lu = 0; mdl_ms = 0;
      end else begin
`ifdef HAZARD_PERF_EN
         if (f_lu() && mdl_lu < SAT) mdl_lu++;
         if (f_busy() && mdl_ms < SAT) mdl_ms++;
`endif
         if (mdl_release) begin
            mdl_release = 0;
         end else if (mdl_req) begin
            mdl_waited++;
            if (dmem_ack) begin
               mdl_req = 0; mdl_release = 1;
            end else if (mdl_waited == TMO) begin
               mdl_req = 0; mdl_release = 1; mdl_err = 1;
            end
         end else if (m_MemRead || m_MemWrite) begin
            mdl_req = 1; mdl_waited = 0;
         end
      end
   end

   always @(negedge clk) begin
      chk("dmem_req",     dmem_req,     rst_n && mdl_req);
      chk("pc_stall",     pc_stall,     f_busy() || f_lu());
      chk("if_id_stall",  if_id_stall,  f_busy() || f_lu());
      chk("id_ex_stall",  id_ex_stall,  f_busy());
      chk("ex_m_stall",   ex_m_stall,   f_busy());
      chk("m_wb_flush",   m_wb_flush,   f_busy());
      chk("if_id_flush",  if_id_flush,  f_redir());
      chk("id_ex_flush",  id_ex_flush,  f_redir() || f_lu());
      chk("mem_err",      mem_err,      mdl_err);
      chk("loaduse_cnt",  loaduse_cnt,  mdl_lu);
      chk("memstall_cnt", memstall_cnt, mdl_ms);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ins();
      id_rs1 = 0; id_rs2 = 0; ex_rd = 0; ex_MemRead = 0; ex_redirect = 0;
      m_MemRead = 0; m_MemWrite = 0; dmem_ack = 0;
   endtask

   // Run one access from an idle cycle; ack_k = cycle index of the ack (0 = none).
   // Index 0 is the detect cycle, 1.. are request cycles.
   task automatic access(input bit wr, input int ack_k,
                         output int req_hi, output int stall_hi, output int flush_hi);
      int done_k;
      done_k = (ack_k != 0) ? ack_k + 1 : TMO + 1;
      req_hi = 0; stall_hi = 0; flush_hi = 0;
      for (int k = 0; k < done_k + 3; k++) begin
         if (k > 0) step();
         if (k == 0) begin
            if (wr) m_MemWrite = 1; else m_MemRead = 1;
         end
         ex_redirect = (k == 1);
         if (ack_k != 0 && k == ack_k) dmem_ack = 1;
         if (k == done_k) begin
            dmem_ack = 0; m_MemRead = 0; m_MemWrite = 0;
         end
         @(negedge clk);
         if (k == 1) chk("redirect_masked_by_mem", if_id_flush, 1'b0);
         req_hi   += int'(dmem_req);
         stall_hi += int'(pc_stall && ex_m_stall);
         flush_hi += int'(m_wb_flush);
      end
   endtask

   initial begin
      int rq, st, fl, ms0;
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int rq, st, fl, ms0;
      // Reset with a pending access and ack: everything quiet until release.
      m_MemRead = 1; dmem_ack = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_pc_stall", pc_stall, 1'b0);
         chk("rst_dmem_req", dmem_req, 1'b0);
      end
      step(); rst_n = 1;
      @(negedge clk);
      chk("rel_detect_stall", pc_stall, 1'b1);
      chk("rel_detect_req", dmem_req, 1'b0);
      step();
      @(negedge clk);
      chk("rel_req_entered", dmem_req, 1'b1);
      step(); m_MemRead = 0; dmem_ack = 0;
      @(negedge clk);
      chk("rel_done_req", dmem_req, 1'b0);
      chk("rel_done_stall", pc_stall, 1'b0);
      step();

      // Load-use on rs2, then x0, then redirect together with a match.
      ex_MemRead = 1; ex_rd = 5; id_rs2 = 5;
      @(negedge clk);
      chk("lu_pc_stall", pc_stall, 1'b1);
      chk("lu_id_ex_flush", id_ex_flush, 1'b1);
      chk("lu_id_ex_stall", id_ex_stall, 1'b0);
      step(); clear_ins();
      @(negedge clk);
      chk("lu_one_bubble", pc_stall, 1'b0);
      step(); ex_MemRead = 1; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
      @(negedge clk);
      chk("x0_pc_stall", pc_stall, 1'b0);
      chk("x0_id_ex_flush", id_ex_flush, 1'b0);
      step(); ex_rd = 7; id_rs1 = 7; ex_redirect = 1;
      @(negedge clk);
      chk("redir_if_id_flush", if_id_flush, 1'b1);
      chk("redir_id_ex_flush", id_ex_flush, 1'b1);
      chk("redir_pc_stall", pc_stall, 1'b0);
      step(); clear_ins();

      // Store acked on the 3rd request cycle.
      ms0 = memstall_cnt;
      access(1'b1, 3, rq, st, fl);
      chk("wait_req_cycles", rq, 3);
      chk("wait_stall_cycles", st, 4);
      chk("wait_flush_cycles", fl, 4);
      chk("wait_mem_err", mem_err, 1'b0);
`ifdef HAZARD_PERF_EN
      chk("wait_memstall_delta", memstall_cnt - CW'(ms0), 4);
`else
      chk("wait_memstall_off", memstall_cnt, 0);
`endif
      // Ack on the last allowed cycle wins over the timeout.
      step();
      access(1'b0, TMO, rq, st, fl);
      chk("late_ack_req_cycles", rq, TMO);
      chk("late_ack_mem_err", mem_err, 1'b0);

      // Timeout with no ack.
      step();
      access(1'b0, 0, rq, st, fl);
      chk("tmo_req_cycles", rq, TMO);
      chk("tmo_mem_err", mem_err, 1'b1);
      repeat (3) step();
      @(negedge clk);
      chk("tmo_err_sticky", mem_err, 1'b1);

      // Reset in the middle of a request.
      step(); m_MemRead = 1;
      step();
      step();
      @(negedge clk);
      chk("midreq_req_before", dmem_req, 1'b1);
      #2 rst_n = 0;
      #1;
      chk("midreq_async_req", dmem_req, 1'b0);
      chk("midreq_async_err", mem_err, 1'b0);
      m_MemRead = 0;
      step(); rst_n = 1;
      @(negedge clk);
      chk("midreq_after_req", dmem_req, 1'b0);
      step();
      access(1'b0, 0, rq, st, fl);
      chk("midreq_counter_cleared", rq, TMO);

      // Long load-use run to saturate the counter.
      step(); clear_ins();
      ex_MemRead = 1; ex_rd = 9; id_rs1 = 9;
      repeat (SAT + 5) step();
      @(negedge clk);
`ifdef HAZARD_PERF_EN
      chk("loaduse_saturated", loaduse_cnt, SAT);
`else
      chk("loaduse_off", loaduse_cnt, 0);
`endif
      step(); clear_ins();
      repeat (2) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
